// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one mem_system between the fetch (read-only) and the
// memory (read/write) pipeline stages. Round-robin on contention, one
// latched request per transaction, createdump on halt while idle.
// Optional watchdog: define MEM_ARB_TIMEOUT_EN to abort stuck transactions
// after TIMEOUT busy cycles and raise a sticky err.
// Handshake: a requester holds xRd/xWr high; the arbiter answers with a
// one-cycle xDone carrying read data, and xStall is high until that cycle.
module mem_arbiter #(
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          iRd,
  input  logic [AW-1:0] iAddr,
  output logic [DW-1:0] iData,
  output logic          iDone,
  output logic          iStall,
  input  logic          dRd,
  input  logic          dWr,
  input  logic [AW-1:0] dAddr,
  input  logic [DW-1:0] dWriteData,
  output logic [DW-1:0] dReadData,
  output logic          dDone,
  output logic          dStall,
  input  logic          halt,
  output logic [AW-1:0] mAddr,
  output logic [DW-1:0] mDataIn,
  output logic          mRd,
  output logic          mWr,
  input  logic [DW-1:0] mDataOut,
  input  logic          mDone,
  output logic          createdump,
  output logic          err,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY_I = 2'd1, BUSY_D = 2'd2} state_t;

  state_t        state, state_nx;
  logic          last_d, last_d_nx;  // 1: the most recent grant went to the data port
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          wr_q;
  logic          grant_i, grant_d;
  logic          busy;
  logic          timeout_hit;
  logic          d_req;

  assign d_req     = dRd | dWr;
  assign busy      = (state != IDLE);
  assign dbg_state = state;

  // Next-state and grant selection; contention goes to the port not served last.
  always_comb begin
    state_nx  = state;
    last_d_nx = last_d;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    unique case (state)
      IDLE: begin
        if (!halt) begin
          if (iRd && d_req) begin
            grant_i = last_d;
            grant_d = ~last_d;
          end else begin
            grant_i = iRd;
            grant_d = d_req;
          end
          if (grant_i) begin
            state_nx  = BUSY_I;
            last_d_nx = 1'b0;
          end else if (grant_d) begin
            state_nx  = BUSY_D;
            last_d_nx = 1'b1;
          end
        end
      end
      BUSY_I, BUSY_D: begin
        if (mDone || timeout_hit) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, round-robin pointer and the latched request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      last_d  <= 1'b1;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
    end else begin
      state  <= state_nx;
      last_d <= last_d_nx;
      if (grant_i) begin
        addr_q  <= iAddr;
        wdata_q <= '0;
        wr_q    <= 1'b0;
      end else if (grant_d) begin
        addr_q  <= dAddr;
        wdata_q <= dWriteData;
        wr_q    <= dWr;
      end
    end
  end

  // mem_system drive and requester responses; command drops in the done cycle.
  always_comb begin
    mAddr      = '0;
    mDataIn    = '0;
    mRd        = 1'b0;
    mWr        = 1'b0;
    iData      = '0;
    iDone      = 1'b0;
    dReadData  = '0;
    dDone      = 1'b0;
    unique case (state)
      BUSY_I: begin
        mAddr = addr_q;
        mRd   = ~mDone & ~timeout_hit;
        if (mDone) begin
          iDone = 1'b1;
          iData = mDataOut;
        end
      end
      BUSY_D: begin
        mAddr   = addr_q;
        mDataIn = wdata_q;
        mRd     = ~wr_q & ~mDone & ~timeout_hit;
        mWr     = wr_q & ~mDone & ~timeout_hit;
        if (mDone) begin
          dDone     = 1'b1;
          dReadData = mDataOut;
        end
      end
      default: ;
    endcase
  end

  // Stalls and createdump depend directly on inputs, so force them low in reset.
  assign iStall     = rst & iRd & ~iDone;
  assign dStall     = rst & d_req & ~dDone;
  assign createdump = rst & halt & (state == IDLE);

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] tcnt;
  logic          err_q;

  // The last allowed busy cycle without mDone aborts the transaction.
  assign timeout_hit = busy & ~mDone & (tcnt == CW'(TIMEOUT - 1));
  assign err         = rst & (err_q | timeout_hit);

  // Busy-cycle counter, cleared on every grant; err stays set until reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tcnt  <= '0;
      err_q <= 1'b0;
    end else begin
      if (grant_i || grant_d) tcnt <= '0;
      else if (busy && !mDone) tcnt <= tcnt + 1'b1;
      if (timeout_hit) err_q <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 3-cycle mem_system model.
module tb_mem_arbiter;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int W  = 17;  // {port, data}: port 0 = fetch, 1 = data

  logic          clk, rst;
  logic          iRd, iDone, iStall;
  logic [AW-1:0] iAddr;
  logic [DW-1:0] iData;
  logic          dRd, dWr, dDone, dStall;
  logic [AW-1:0] dAddr;
  logic [DW-1:0] dWriteData, dReadData;
  logic          halt, mRd, mWr, mDone, createdump, err;
  logic [AW-1:0] mAddr;
  logic [DW-1:0] mDataIn, mDataOut;
  logic [1:0]    dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];

  mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .iRd(iRd), .iAddr(iAddr), .iData(iData), .iDone(iDone), .iStall(iStall),
    .dRd(dRd), .dWr(dWr), .dAddr(dAddr), .dWriteData(dWriteData),
    .dReadData(dReadData), .dDone(dDone), .dStall(dStall),
    .halt(halt), .mAddr(mAddr), .mDataIn(mDataIn), .mRd(mRd), .mWr(mWr),
    .mDataOut(mDataOut), .mDone(mDone), .createdump(createdump), .err(err),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- mem_system model ----------------
  bit [15:0] mem_data  [0:1023];
  bit        mem_valid [0:1023];
  logic [7:0] mcnt;
  bit hold = 1'b0;

  function automatic logic [15:0] fill(input logic [15:0] a);
    return (a == 16'h0010) ? 16'hBEEF : (a ^ 16'hA5A5);
  endfunction

  assign mDone    = (mcnt == 8'd3) && !hold;
  assign mDataOut = mem_valid[mAddr[9:0]] ? mem_data[mAddr[9:0]] : fill(mAddr);

  always @(posedge clk or negedge rst) begin
    if (!rst) mcnt <= '0;
    else if (mDone) mcnt <= '0;
    else if (mRd || mWr) mcnt <= mcnt + 8'd1;
  end

  always @(posedge clk) begin
    if (rst && mWr) begin
      mem_data[mAddr[9:0]]  <= mDataIn;
      mem_valid[mAddr[9:0]] <= 1'b1;
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    iRd = 0; dRd = 0; dWr = 0; halt = 0;
    rst = 0;
    tick();
    rst = 1;
    tick();
  endtask

  task automatic do_txn(input bit is_d, input bit is_wr, input logic [15:0] a,
                        input logic [15:0] wd, output int stalls, output int cmds,
                        output int bad, output int dones, output logic [15:0] rdata);
    stalls = 0; cmds = 0; bad = 0; dones = 0; rdata = '0;
    if (is_d) begin
      dAddr = a; dWriteData = wd; dWr = is_wr; dRd = !is_wr;
    end else begin
      iAddr = a; iRd = 1;
    end
    for (int c = 0; c < 40; c++) begin
      #1;
      if (is_d ? dStall : iStall) stalls++;
      if (mRd || mWr) begin
        cmds++;
        if (mAddr !== a || mWr !== is_wr || (is_wr && mDataIn !== wd)) bad++;
      end
      if (is_d ? dDone : iDone) begin
        dones++;
        rdata = is_d ? dReadData : iData;
        break;
      end
      tick();
    end
    tick();
    iRd = 0; dRd = 0; dWr = 0;
  endtask

  // ---------------- stimulus ----------------
  int stalls, cmds, bad, dones, last_c, first_err;
  logic [15:0] rdata;

  initial begin
    rst = 0; halt = 1; iRd = 1; dRd = 0; dWr = 1;
    iAddr = 16'h0010; dAddr = 16'h0200; dWriteData = 16'h1234;
    #3;
    check("rst_istall", iStall, 0);
    check("rst_dstall", dStall, 0);
    check("rst_dump", createdump, 0);
    check("rst_mcmd", {mRd, mWr}, 0);
    check("rst_maddr", mAddr, 0);
    check("rst_err", err, 0);
    tick();
    iRd = 0; dWr = 0; halt = 0;
    rst = 1;
    tick();

    // Fetch only: 3-cycle memory, 4 stall cycles, single done pulse.
    do_txn(0, 0, 16'h0010, 16'h0000, stalls, cmds, bad, dones, rdata);
    check("f_stalls", stalls, 4);
    check("f_mrd_cycles", cmds, 3);
    check("f_cmd_fields", bad, 0);
    check("f_done", dones, 1);
    check("f_data", rdata, 16'hBEEF);
    #1;
    check("f_idone_after", iDone, 0);
    check("f_idata_idle", iData, 0);
    tick();

    // Data write then read-back.
    do_txn(1, 1, 16'h0200, 16'h1234, stalls, cmds, bad, dones, rdata);
    check("w_stalls", stalls, 4);
    check("w_mwr_cycles", cmds, 3);
    check("w_cmd_fields", bad, 0);
    check("w_done", dones, 1);
    do_txn(1, 0, 16'h0200, 16'h0000, stalls, cmds, bad, dones, rdata);
    check("r_done", dones, 1);
    check("r_data", rdata, 16'h1234);

    // Continuous contention after reset: fetch, data, fetch, data.
    pulse_reset();
    exp_q.push_back({1'b0, 16'hA595});
    exp_q.push_back({1'b1, 16'hA594});
    exp_q.push_back({1'b0, 16'hA595});
    exp_q.push_back({1'b1, 16'hA594});
    iAddr = 16'h0030; dAddr = 16'h0031; iRd = 1; dRd = 1;
    last_c = -1;
    for (int c = 0; c < 60 && exp_q.size() != 0; c++) begin
      #1;
      if (iDone) begin
        check("arb_order", {1'b0, iData}, exp_q.pop_front());
        last_c = c;
      end else if (dDone) begin
        check("arb_order", {1'b1, dReadData}, exp_q.pop_front());
        last_c = c;
      end
      tick();
    end
    iRd = 0; dRd = 0;
    check("arb_drain", exp_q.size(), 0);
    check("arb_last_cycle", last_c, 19);

    // dAddr changes while BUSY_D: mAddr keeps the latched value.
    dRd = 1; dAddr = 16'h0040;
    tick();
    dAddr = 16'h0050;
    bad = 0; dones = 0; rdata = '0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (mRd && mAddr !== 16'h0040) bad++;
      if (dDone) begin
        dones++;
        rdata = dReadData;
        break;
      end
      tick();
    end
    check("hold_addr", bad, 0);
    check("hold_done", dones, 1);
    check("hold_data", rdata, 16'hA5E5);
    tick();
    dRd = 0;
    tick();

    // halt during BUSY_I: completes, then no grant, createdump in IDLE.
    iRd = 1; iAddr = 16'h0010;
    tick();
    halt = 1; dRd = 1; dAddr = 16'h0060;
    #1;
    check("halt_busy_dump", createdump, 0);
    check("halt_busy_mrd", mRd, 1);
    dones = 0; rdata = '0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (iDone) begin
        dones++;
        rdata = iData;
        break;
      end
      tick();
    end
    check("halt_done", dones, 1);
    check("halt_data", rdata, 16'hBEEF);
    tick();
    iRd = 0;
    #1;
    check("halt_idle_dump", createdump, 1);
    check("halt_no_cmd", {mRd, mWr}, 0);
    check("halt_dstall", dStall, 1);
    tick();
    check("halt_still_idle", dbg_state, 0);
    check("halt_dump2", createdump, 1);
    halt = 0;
    do_txn(1, 0, 16'h0060, 16'h0000, stalls, cmds, bad, dones, rdata);
    check("unhalt_stalls", stalls, 4);
    check("unhalt_data", rdata, 16'hA5C5);

    // Reset mid BUSY_D: outputs drop immediately.
    dWr = 1; dAddr = 16'h0080; dWriteData = 16'h5555;
    tick();
    check("rmid_mwr", mWr, 1);
    rst = 0;
    #1;
    check("rmid_cmd", {mRd, mWr}, 0);
    check("rmid_maddr", mAddr, 0);
    check("rmid_mdatain", mDataIn, 0);
    check("rmid_dstall", dStall, 0);
    check("rmid_state", dbg_state, 0);
    dWr = 0;
    tick();
    rst = 1;
    tick();
    check("rpost_cmd", {mRd, mWr}, 0);
    do_txn(0, 0, 16'h0010, 16'h0000, stalls, cmds, bad, dones, rdata);
    check("rpost_stalls", stalls, 4);
    check("rpost_data", rdata, 16'hBEEF);

`ifdef MEM_ARB_TIMEOUT_EN
    // Memory never answers: err on the 8th busy cycle, back to IDLE.
    hold = 1;
    iRd = 1; iAddr = 16'h0010;
    cmds = 0; dones = 0; first_err = -1;
    for (int c = 0; c < 9; c++) begin
      #1;
      if (mRd) cmds++;
      if (iDone) dones++;
      if (err && first_err < 0) first_err = c;
      tick();
    end
    iRd = 0;
    #1;
    check("to_mrd_cycles", cmds, 7);
    check("to_err_cycle", first_err, 8);
    check("to_no_done", dones, 0);
    check("to_idle", dbg_state, 0);
    tick();
    check("to_err_sticky", err, 1);
    pulse_reset();
    hold = 0;
    check("to_err_cleared", err, 0);
`else
    check("err_off", err, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
